// File: rtl/spi_bridge_pkg.sv
// ============================================================================
// spi_bridge_pkg : shared widths for the SPI slave front-end
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_bridge_pkg;
    localparam int SPI_WORD_W = 8;
    localparam int BIT_CNT_W  = 3;
    localparam logic [BIT_CNT_W-1:0] c_LAST_BIT = BIT_CNT_W'(SPI_WORD_W - 1);
endpackage

`default_nettype wire

// File: rtl/spi_bridge.sv
// ============================================================================
// spi_bridge : SPI mode-3 slave, MSB first, 8-bit frames, clocked by sclk
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_bridge
    import spi_bridge_pkg::*;
(
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  clk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  byte_sync,
    output logic [SPI_WORD_W-1:0] data_in,
    input  logic [SPI_WORD_W-1:0] data_out
);

    logic [SPI_WORD_W-1:0] r_rx_shift;
    logic [SPI_WORD_W-1:0] r_tx_shift;
    logic [SPI_WORD_W-1:0] r_data_in;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_byte_sync;
    logic [SPI_WORD_W-1:0] w_rx_next;
    logic                  w_clr_n;
    logic                  w_unused_clk;

    assign w_unused_clk = clk;
    assign w_rx_next    = {r_rx_shift[SPI_WORD_W-2:0], mosi};

    // Deasserting chip select drops the frame position as well as reset does.
    assign w_clr_n = rst_n & ~cs_n;

    always_ff @(posedge sclk or negedge w_clr_n) begin
        if (!w_clr_n) begin
            r_bit_cnt   <= '0;
            r_byte_sync <= 1'b0;
        end else begin
            r_bit_cnt   <= r_bit_cnt + 1'b1;
            r_byte_sync <= (r_bit_cnt == c_LAST_BIT);
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift <= '0;
            r_data_in  <= '0;
        end else if (!cs_n) begin
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt == c_LAST_BIT) begin
                r_data_in <= w_rx_next;
            end
        end
    end

    // A zero count on the falling edge marks the start of a byte: load fresh data.
    always_ff @(negedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '0;
        end else if (!cs_n) begin
            if (r_bit_cnt == '0) begin
                r_tx_shift <= data_out;
            end else begin
                r_tx_shift <= {r_tx_shift[SPI_WORD_W-2:0], 1'b0};
            end
        end
    end

    assign miso      = cs_n ? 1'b0 : r_tx_shift[SPI_WORD_W-1];
    assign byte_sync = r_byte_sync;
    assign data_in   = r_data_in;

endmodule

`default_nettype wire

// File: tb/tb_spi_bridge.sv
// ============================================================================
// tb_spi_bridge : directed self-checking bench for spi_bridge
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_bridge;

    logic       sclk     = 1'b1;
    logic       rst_n    = 1'b0;
    logic       clk      = 1'b0;
    logic       cs_n     = 1'b1;
    logic       mosi     = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       miso;
    logic       byte_sync;
    logic [7:0] data_in;

    int n_checks = 0;
    int n_errors = 0;

    spi_bridge u_dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .clk       (clk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .byte_sync (byte_sync),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    initial forever #1 sclk = ~sclk;

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic start_frame();
        @(posedge sclk);
        #0.5;
        cs_n = 1'b0;
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        #0.2;
        check_val("idle miso", {7'd0, miso}, 8'h00);
        check_val("idle byte_sync", {7'd0, byte_sync}, 8'h00);
    endtask

    // Master drives mosi after each falling edge; data_out is scrambled after
    // the load to prove the byte in flight is insulated from it.
    task automatic shift_bits(input logic [7:0] rx, input logic [7:0] tx, input int nbits);
        data_out = tx;
        for (int i = 7; i >= 8 - nbits; i--) begin
            @(negedge sclk);
            #0.5;
            check_val($sformatf("miso bit%0d tx=%h", i, tx), {7'd0, miso}, {7'd0, tx[i]});
            data_out = ~tx;
            mosi     = rx[i];
            @(posedge sclk);
            #0.5;
            if (i > 0) begin
                check_val($sformatf("byte_sync low bit%0d", i), {7'd0, byte_sync}, 8'h00);
            end else begin
                check_val($sformatf("byte_sync pulse rx=%h", rx), {7'd0, byte_sync}, 8'h01);
                check_val($sformatf("data_in rx=%h", rx), data_in, rx);
            end
        end
    endtask

    initial begin
        #2.3;
        check_val("rst data_in", data_in, 8'h00);
        check_val("rst byte_sync", {7'd0, byte_sync}, 8'h00);
        check_val("rst miso", {7'd0, miso}, 8'h00);
        rst_n    = 1'b1;
        data_out = 8'hFF;
        mosi     = 1'bx;
        repeat (5) @(posedge sclk);
        #0.5;
        check_val("idle5 data_in", data_in, 8'h00);
        check_val("idle5 byte_sync", {7'd0, byte_sync}, 8'h00);
        check_val("idle5 miso", {7'd0, miso}, 8'h00);
        mosi = 1'b0;

        // receive 0x99 while transmitting 0xFA
        start_frame();
        shift_bits(8'h99, 8'hFA, 8);
        @(negedge sclk);
        #0.5;
        check_val("reload miso", {7'd0, miso}, 8'h00);
        @(posedge sclk);
        #0.5;
        check_val("byte_sync drop", {7'd0, byte_sync}, 8'h00);
        check_val("data_in hold", data_in, 8'h99);
        end_frame();

        // abort after 5 bits, then a clean frame
        start_frame();
        shift_bits(8'hF0, 8'h3C, 5);
        end_frame();
        check_val("abort data_in", data_in, 8'h99);
        start_frame();
        shift_bits(8'hA5, 8'h5A, 8);
        end_frame();

        // streaming two bytes under one chip select
        start_frame();
        shift_bits(8'h3C, 8'h81, 8);
        shift_bits(8'hC3, 8'h7E, 8);
        end_frame();

        // reset in the middle of a frame
        start_frame();
        shift_bits(8'hFF, 8'hD2, 4);
        rst_n = 1'b0;
        #0.2;
        check_val("midrst data_in", data_in, 8'h00);
        check_val("midrst byte_sync", {7'd0, byte_sync}, 8'h00);
        check_val("midrst miso", {7'd0, miso}, 8'h00);
        #1.8;
        rst_n = 1'b1;
        shift_bits(8'h6B, 8'hD2, 8);
        end_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
